start_sequencer: RTL and testbench
==================================

START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, the number of ARM cycles without enable_in before the sequencer aborts; legal range 2..255.
REQ-002 Parameter PEND_W, default 3, the width of the pending-request counter.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  one-cycle job request from the user side.
REQ-006 enable_in  input  1  enable output of the 8-step work controller; combinationally high while the controller is loading or working.
REQ-007 start  output  1  registered start level driven to the controller.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when a job completes.
REQ-010 drop  output  1  one-cycle pulse when a req is discarded.
REQ-011 err  output  1  sticky timeout flag.
REQ-012 last_len  output  5  count of enable_in-high cycles in the last completed job.
REQ-013 pending  output  PEND_W  number of queued requests.

Function
REQ-014 The FSM shall have the states IDLE, ARM, RUN and RELEASE; start=1 exactly in ARM and RUN.
REQ-015 IDLE: req sampled high shall move the FSM to ARM, clear err and clear the length and timeout counters.
REQ-016 ARM: enable_in sampled high shall move the FSM to RUN and set len=1; otherwise the timeout counter shall increment.
REQ-017 ARM: when the timeout counter reaches TIMEOUT-1 with enable_in low, the FSM shall go to IDLE, set err=1 and leave last_len unchanged.
REQ-018 RUN: each cycle with enable_in high shall increment len, saturating at 31.
REQ-019 RUN: enable_in sampled low shall move the FSM to RELEASE, load last_len with len and pulse done in the first RELEASE cycle.
REQ-020 RELEASE shall last exactly one cycle with start=0, so the controller returns to its wait state before any new start.
REQ-021 On leaving RELEASE, the FSM shall go to ARM if pending>0, decrementing pending, otherwise to IDLE.
REQ-022 Nominal job: enable_in stays high 10 cycles (1 load + 9 work), giving last_len=10; from the req edge to the done pulse is 12 cycles.
REQ-023 A req in any state other than IDLE shall be handled per the configuration (REQ-027/REQ-028).
REQ-024 A req in the same cycle as the RELEASE-to-IDLE transition shall count as busy-state; it shall not be lost silently (queued or dropped).

Reset
REQ-025 resetn low shall immediately and asynchronously force state=IDLE, start=0, busy=0, done=0, drop=0, err=0, last_len=0, pending=0 and all internal counters to 0.
REQ-026 A reset during ARM or RUN shall abandon the job with no done pulse; start falls asynchronously with reset.

Configuration
REQ-027 With macro START_SEQUENCER_QUEUE_EN defined: a busy-state req shall increment pending; a req with pending at 2^PEND_W-1 shall pulse drop and leave pending unchanged.
REQ-028 Without START_SEQUENCER_QUEUE_EN: a busy-state req shall pulse drop; the pending port shall remain, tied to 0.
REQ-029 err shall be cleared only by an accepted req, whether taken from IDLE or dequeued from pending, or by reset.

Verification
REQ-030 Single job: req pulse, model controller with 10-cycle enable -> start high for 11 cycles, done on cycle 12, last_len=10, busy falls the cycle after done.
REQ-031 Timeout (TIMEOUT=16): req, enable_in held 0 -> start drops after 16 ARM cycles, err=1, no done pulse, last_len holds its prior value; next req clears err.
REQ-032 Queue on (PEND_W=3): 3 reqs during RUN -> pending=3, then three back-to-back jobs each separated by exactly one start-low cycle, with 4 done pulses total.
REQ-033 Queue overflow on: 8 reqs during RUN -> pending=7, one drop pulse.
REQ-034 Queue off: req during RUN -> drop pulse, pending=0, the running job still completes with last_len=10.
REQ-035 Reset mid-RUN: resetn low at cycle 5 of enable -> start=0 in the same cycle, no done pulse, all outputs 0; a new req after release gives a normal job.

Source files
------------

// File: rtl/start_sequencer_if.sv
// Handshake bundle between the user side, the work controller and the start sequencer.
// The master side issues req and returns the controller's enable; the slave side is the sequencer.
interface start_sequencer_if #(
  parameter int unsigned PEND_W = 3
) ();
  logic              req;
  logic              enable_in;
  logic              start;
  logic              busy;
  logic              done;
  logic              drop;
  logic              err;
  logic [4:0]        last_len;
  logic [PEND_W-1:0] pending;

  modport master (
    output req, enable_in,
    input  start, busy, done, drop, err, last_len, pending
  );

  modport slave (
    input  req, enable_in,
    output start, busy, done, drop, err, last_len, pending
  );
endinterface

// File: rtl/start_sequencer.sv
// Start sequencer: arms an 8-step work controller on request, measures how long its enable
// stays high, aborts on timeout and forces a one-cycle start-low gap between jobs.
// Optional request queue enabled by defining START_SEQUENCER_QUEUE_EN; without it, requests
// arriving while busy are dropped and pending reads 0.
module start_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PEND_W  = 3
) (
  input logic              clock,
  input logic              resetn,
  start_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StRelease} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] last_len_q, last_len_d;
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;
  logic       start_q, start_d;
  logic       busy_req;

`ifdef START_SEQUENCER_QUEUE_EN
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              q_full, q_push, pop;
`endif

  // Next-state, counters and queue bookkeeping
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    last_len_d = last_len_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    // A req seen in any non-idle state (including RELEASE) is a busy-state req
    busy_req   = bus.req && (state_q != StIdle);
`ifdef START_SEQUENCER_QUEUE_EN
    q_full     = (pending_q == {PEND_W{1'b1}});
    q_push     = busy_req && !q_full;
    drop_d     = busy_req && q_full;
    pop        = 1'b0;
`else
    drop_d     = busy_req;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StArm;
          err_d   = 1'b0;
          len_d   = 5'd0;
          tmo_d   = 8'd0;
        end
      end
      StArm: begin
        if (bus.enable_in) begin
          state_d = StRun;
          len_d   = 5'd1;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StRun: begin
        if (bus.enable_in) begin
          if (len_q != 5'd31) len_d = len_q + 5'd1;
        end else begin
          state_d    = StRelease;
          last_len_d = len_q;
        end
      end
      StRelease: begin
`ifdef START_SEQUENCER_QUEUE_EN
        // A req landing in this very cycle is queued and may be served straight away
        if ((pending_q != '0) || q_push) begin
          state_d = StArm;
          err_d   = 1'b0;
          len_d   = 5'd0;
          tmo_d   = 8'd0;
          pop     = 1'b1;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

`ifdef START_SEQUENCER_QUEUE_EN
    pending_d = pending_q + PEND_W'(q_push) - PEND_W'(pop);
`endif
    start_d = (state_d == StArm) || (state_d == StRun);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      len_q      <= 5'd0;
      last_len_q <= 5'd0;
      tmo_q      <= 8'd0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      last_len_q <= last_len_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      start_q    <= start_d;
    end
  end

`ifdef START_SEQUENCER_QUEUE_EN
  // Pending-request counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign bus.pending = pending_q;
`else
  assign bus.pending = {PEND_W{1'b0}};
`endif

  assign bus.start    = start_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StRelease);
  assign bus.drop     = drop_q;
  assign bus.err      = err_q;
  assign bus.last_len = last_len_q;

endmodule

// File: tb/tb_start_sequencer.sv
// Directed bench for start_sequencer with a simple work-controller model driving enable_in.
module tb_start_sequencer;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  start_sequencer_if #(.PEND_W(3)) bus ();

  start_sequencer #(
    .TIMEOUT(16),
    .PEND_W (3)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Controller model: enable high for ctl_len cycles from the first start-high cycle
  int ctl_len = 10;
  int ctl_cnt;
  always @(posedge clock or negedge resetn) begin
    if (!resetn)         ctl_cnt <= 0;
    else if (!bus.start) ctl_cnt <= 0;
    else if (ctl_cnt < 1000) ctl_cnt <= ctl_cnt + 1;
  end
  assign bus.enable_in = bus.start && (ctl_cnt < ctl_len);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, start_cnt, done_cnt, drop_cnt, last_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; start_cnt = 0; done_cnt = 0; drop_cnt = 0; last_done_cyc = 0;
  endtask

  // One clock, then sample 1 ns after the edge and accumulate pulse statistics
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.start) start_cnt++;
    if (bus.done) begin done_cnt++; last_done_cyc = cyc; end
    if (bus.drop) drop_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_req();
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
  endtask

  initial begin
    bus.req = 1'b0;
    #2;
    // Reset state, before any clock edge
    check("rst_start", bus.start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_last_len", bus.last_len, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_drop", bus.drop, 0);
    steps(2);
    resetn = 1'b1;
    steps(2);

    // Nominal single job
    clear_stats();
    pulse_req();
    check("job_busy_c1", bus.busy, 1);
    check("job_start_c1", bus.start, 1);
    steps(11);
    check("job_done_c12", bus.done, 1);
    check("job_busy_c12", bus.busy, 1);
    step();
    check("job_busy_c13", bus.busy, 0);
    check("job_start_cnt", start_cnt, 11);
    check("job_done_cnt", done_cnt, 1);
    check("job_last_len", bus.last_len, 10);
    check("job_err", bus.err, 0);

    // Short job
    ctl_len = 3;
    clear_stats();
    pulse_req();
    steps(6);
    check("short_last_len", bus.last_len, 3);
    check("short_done_cyc", last_done_cyc, 5);
    check("short_idle", bus.busy, 0);

    // Length saturation
    ctl_len = 40;
    clear_stats();
    pulse_req();
    steps(45);
    check("sat_last_len", bus.last_len, 31);
    check("sat_done_cnt", done_cnt, 1);

    // Timeout with enable held low
    ctl_len = 0;
    clear_stats();
    pulse_req();
    steps(15);
    check("tmo_start_c16", bus.start, 1);
    check("tmo_err_c16", bus.err, 0);
    step();
    check("tmo_start_c17", bus.start, 0);
    check("tmo_busy_c17", bus.busy, 0);
    check("tmo_err", bus.err, 1);
    check("tmo_start_cnt", start_cnt, 16);
    check("tmo_done_cnt", done_cnt, 0);
    check("tmo_last_len", bus.last_len, 31);
    steps(3);
    check("tmo_err_sticky", bus.err, 1);

    // Next req clears err and runs normally
    ctl_len = 10;
    clear_stats();
    pulse_req();
    check("clr_err", bus.err, 0);
    steps(12);
    check("clr_last_len", bus.last_len, 10);
    check("clr_done_cnt", done_cnt, 1);

`ifdef START_SEQUENCER_QUEUE_EN
    // Three queued reqs during RUN -> four back-to-back jobs
    clear_stats();
    pulse_req();
    step();
    bus.req = 1'b1;
    steps(3);
    bus.req = 1'b0;
    check("q3_pending", bus.pending, 3);
    steps(48 - cyc);
    check("q3_done_cnt", done_cnt, 4);
    check("q3_last_done", last_done_cyc, 48);
    check("q3_start_cnt", start_cnt, 44);
    check("q3_drop_cnt", drop_cnt, 0);
    step();
    check("q3_idle", bus.busy, 0);
    check("q3_pending_end", bus.pending, 0);

    // Overflow: eight reqs during RUN
    clear_stats();
    pulse_req();
    step();
    bus.req = 1'b1;
    steps(8);
    bus.req = 1'b0;
    check("ovf_pending", bus.pending, 7);
    check("ovf_drop_cnt", drop_cnt, 1);
    for (int i = 0; i < 200 && bus.busy; i++) step();
    check("ovf_drained", bus.busy, 0);
    check("ovf_done_cnt", done_cnt, 8);
    check("ovf_drop_total", drop_cnt, 1);

    // Req landing in the RELEASE cycle is queued and served at once
    clear_stats();
    pulse_req();
    steps(11);
    check("rel_done_c12", bus.done, 1);
    pulse_req();
    check("rel_start_c13", bus.start, 1);
    check("rel_pending", bus.pending, 0);
    steps(11);
    check("rel_done_c24", bus.done, 1);
    step();
    check("rel_idle", bus.busy, 0);
    check("rel_drop_cnt", drop_cnt, 0);
`else
    // Queue off: busy-state req is dropped, job still completes
    clear_stats();
    pulse_req();
    step();
    pulse_req();
    check("noq_drop_pulse", bus.drop, 1);
    check("noq_pending", bus.pending, 0);
    steps(10);
    check("noq_idle", bus.busy, 0);
    check("noq_done_cnt", done_cnt, 1);
    check("noq_last_len", bus.last_len, 10);
    check("noq_drop_cnt", drop_cnt, 1);

    // Req landing in the RELEASE cycle is dropped, not lost silently
    clear_stats();
    pulse_req();
    steps(11);
    check("rel_done_c12", bus.done, 1);
    pulse_req();
    check("rel_drop", bus.drop, 1);
    check("rel_idle", bus.busy, 0);
    step();
    check("rel_still_idle", bus.busy, 0);
`endif

    // Reset in the middle of RUN
    clear_stats();
    pulse_req();
    steps(4);
    check("mid_start_c5", bus.start, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_start", bus.start, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_done", bus.done, 0);
    check("mid_last_len", bus.last_len, 0);
    check("mid_err", bus.err, 0);
    check("mid_pending", bus.pending, 0);
    check("mid_drop", bus.drop, 0);
    steps(2);
    resetn = 1'b1;
    steps(2);
    check("mid_no_done", done_cnt, 0);
    clear_stats();
    pulse_req();
    steps(11);
    check("mid_new_done_c12", bus.done, 1);
    step();
    check("mid_new_last_len", bus.last_len, 10);
    check("mid_new_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
